// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_master
// Function : Single-outstanding AHB-Lite initiator (command in, response out)
// Revision : 1.0
// ============================================================================
module ahb_lite_master #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic [31:0] HRDATA,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0]       c_htrans_idle   = 2'b00;
  localparam logic [1:0]       c_htrans_nonseq = 2'b10;
  localparam logic [2:0]       c_hsize_word    = 3'b010;
  localparam logic [CNT_W-1:0] c_cnt_max       = {CNT_W{1'b1}};
  localparam logic [CNT_W:0]   c_timeout       = (CNT_W+1)'(TIMEOUT_CYCLES);

  state_t            r_state;
  logic [31:0]       r_haddr;
  logic [1:0]        r_htrans;
  logic              r_hwrite;
  logic [31:0]       r_hwdata;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_timeout;
  logic [CNT_W:0]    w_cnt_next;

  // One extra bit so the saturated value still compares above the limit.
  assign w_cnt_next = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_haddr     <= '0;
      r_htrans    <= c_htrans_idle;
      r_hwrite    <= 1'b0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_haddr   <= cmd_addr;
            r_hwrite  <= cmd_write;
            r_wdata   <= cmd_wdata;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_htrans  <= c_htrans_nonseq;
            r_state   <= S_ADDR;
          end
        end
        S_ADDR: begin
          // A low HREADY here belongs to the previous transfer, not ours.
          if (HREADY) begin
            r_htrans <= c_htrans_idle;
            if (r_hwrite) begin
              r_hwdata <= r_wdata;
            end
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (!HREADY) begin
            if (r_cnt != c_cnt_max) begin
              r_cnt <= w_cnt_next[CNT_W-1:0];
            end
            if (w_cnt_next >= c_timeout) begin
              r_timeout <= 1'b1;
            end
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= HRESP;
            r_rsp_rdata <= (!r_hwrite && !HRESP) ? HRDATA : 32'h0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_htrans <= c_htrans_idle;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready    = (r_state == S_IDLE);
  assign HADDR        = r_haddr;
  assign HTRANS       = r_htrans;
  assign HWRITE       = r_hwrite;
  assign HSIZE        = c_hsize_word;
  assign HWDATA       = r_hwdata;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_err      = r_rsp_err;
  assign timeout_flag = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_master
// Function : Self-checking bench for ahb_lite_master with a scripted slave
// Revision : 1.0
// ============================================================================
module tb_ahb_lite_master;

  localparam int TO = 16;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        timeout_flag;

  int total = 0;
  int bad   = 0;

  // Reference state of the block's visible, held outputs
  logic [31:0] m_hwdata;
  logic [31:0] m_rdata;
  logic        m_err;
  logic        m_timeout;

  ahb_lite_master #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .timeout_flag(timeout_flag)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full transfer: idle cycle, address phase (with stalls), data phase
  // (with wait states), completion pulse, and one held-response cycle.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int stall, input int waits,
                         input bit err, input string name);
    logic [31:0] exp_rdata;
    bit          exp_to;
    @(negedge HCLK);
    total++;
    if ({cmd_ready, HTRANS, rsp_valid, timeout_flag, rsp_err, rsp_rdata, HWDATA} !==
        {1'b1, 2'b00, 1'b0, m_timeout, m_err, m_rdata, m_hwdata}) begin
      bad++;
      $display("FAIL %s idle: got rdy=%b tr=%b v=%b to=%b e=%b rd=%h wd=%h exp rdy=1 tr=00 v=0 to=%b e=%b rd=%h wd=%h",
               name, cmd_ready, HTRANS, rsp_valid, timeout_flag, rsp_err, rsp_rdata, HWDATA,
               m_timeout, m_err, m_rdata, m_hwdata);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    HREADY = 1'($urandom); HRESP = 1'b0; HRDATA = $urandom;
    @(posedge HCLK);
    for (int s = 0; s <= stall; s++) begin
      @(negedge HCLK);
      total++;
      if ({HTRANS, HADDR, HWRITE, cmd_ready, timeout_flag, rsp_valid, HWDATA} !==
          {2'b10, addr, wr, 1'b0, 1'b0, 1'b0, m_hwdata}) begin
        bad++;
        $display("FAIL %s addr[%0d]: got tr=%b a=%h w=%b rdy=%b to=%b v=%b wd=%h exp tr=10 a=%h w=%b rdy=0 to=0 v=0 wd=%h",
                 name, s, HTRANS, HADDR, HWRITE, cmd_ready, timeout_flag, rsp_valid, HWDATA,
                 addr, wr, m_hwdata);
      end
      cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      HREADY = (s == stall); HRESP = 1'b0; HRDATA = $urandom;
      @(posedge HCLK);
    end
    if (wr) m_hwdata = wdata;
    for (int w = 0; w <= waits; w++) begin
      @(negedge HCLK);
      exp_to = (w >= TO);
      total++;
      if ({HTRANS, HWDATA, cmd_ready, rsp_valid, timeout_flag} !==
          {2'b00, m_hwdata, 1'b0, 1'b0, exp_to}) begin
        bad++;
        $display("FAIL %s data[%0d]: got tr=%b wd=%h rdy=%b v=%b to=%b exp tr=00 wd=%h rdy=0 v=0 to=%b",
                 name, w, HTRANS, HWDATA, cmd_ready, rsp_valid, timeout_flag, m_hwdata, exp_to);
      end
      cmd_valid = 1'b0;
      HREADY = (w == waits);
      HRESP  = err && (w >= waits - 1);
      HRDATA = (w == waits) ? rdata : $urandom;
    @(posedge HCLK);
    end
    exp_rdata = (!wr && !err) ? rdata : 32'h0;
    exp_to    = (waits >= TO);
    @(negedge HCLK);
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, timeout_flag, cmd_ready, HTRANS} !==
        {1'b1, err, exp_rdata, exp_to, 1'b1, 2'b00}) begin
      bad++;
      $display("FAIL %s done: got v=%b e=%b rd=%h to=%b rdy=%b tr=%b exp v=1 e=%b rd=%h to=%b rdy=1 tr=00",
               name, rsp_valid, rsp_err, rsp_rdata, timeout_flag, cmd_ready, HTRANS, err, exp_rdata, exp_to);
    end
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
    @(negedge HCLK);
    total++;
    if ({rsp_valid, rsp_err, rsp_rdata, timeout_flag} !== {1'b0, err, exp_rdata, exp_to}) begin
      bad++;
      $display("FAIL %s hold: got v=%b e=%b rd=%h to=%b exp v=0 e=%b rd=%h to=%b",
               name, rsp_valid, rsp_err, rsp_rdata, timeout_flag, err, exp_rdata, exp_to);
    end
    m_rdata = exp_rdata; m_err = err; m_timeout = exp_to;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (3) @(negedge HCLK);
    total++;
    if ({HTRANS, HADDR, HWRITE, HWDATA, HSIZE, cmd_ready, rsp_valid, rsp_rdata, rsp_err, timeout_flag} !==
        {2'b00, 32'h0, 1'b0, 32'h0, 3'b010, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got tr=%b a=%h w=%b wd=%h sz=%b rdy=%b v=%b rd=%h e=%b to=%b exp all zero, sz=010 rdy=1",
               HTRANS, HADDR, HWRITE, HWDATA, HSIZE, cmd_ready, rsp_valid, rsp_rdata, rsp_err, timeout_flag);
    end
    HRESETn = 1'b1;
    m_hwdata = '0; m_rdata = '0; m_err = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic test_write_min();
    run_txn(1'b1, 32'h0000_3A7C, 32'hFFFF_FFFF, 32'h1234_5678, 0, 0, 1'b0, "write_min");
  endtask

  task automatic test_read_waits();
    run_txn(1'b0, 32'h0000_1D3A, 32'h0, 32'hDEAD_BEEF, 0, 2, 1'b0, "read_2wait");
  endtask

  task automatic test_error();
    run_txn(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 1, 1'b1, "read_error");
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 32'h0000_0100, 32'hA5A5_5A5A, 32'h0, 0, 20, 1'b0, "timeout_20");
    run_txn(1'b0, 32'h0000_0104, 32'h0, 32'h0BAD_F00D, 0, 15, 1'b0, "wait_15");
    run_txn(1'b0, 32'h0000_0108, 32'h0, 32'h1111_2222, 0, 16, 1'b0, "wait_16");
    run_txn(1'b1, 32'h0000_010C, 32'h3333_4444, 32'h0, 0, 35, 1'b0, "wait_sat");
  endtask

  task automatic test_addr_stall();
    run_txn(1'b0, 32'h0000_0200, 32'h0, 32'h5555_6666, 18, 0, 1'b0, "addr_stall18");
    run_txn(1'b1, 32'h0000_0204, 32'h7777_8888, 32'h0, 2, 1, 1'b0, "addr_stall2");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w_data, r_data, a2;
    bit exp_issue, exp_done;
    w_data = $urandom; r_data = $urandom; a2 = $urandom;
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0300; cmd_wdata = w_data;
    HREADY = 1'b1; HRESP = 1'b0;
    @(posedge HCLK);
    for (int k = 0; k < 6; k++) begin
      @(negedge HCLK);
      exp_issue = (k == 0) || (k == 3);
      exp_done  = (k == 2) || (k == 5);
      total++;
      if ({HTRANS, cmd_ready, rsp_valid} !== {exp_issue ? 2'b10 : 2'b00, exp_done, exp_done}) begin
        bad++;
        $display("FAIL b2b[%0d] ctrl: got tr=%b rdy=%b v=%b exp tr=%b rdy=%b v=%b",
                 k, HTRANS, cmd_ready, rsp_valid, exp_issue ? 2'b10 : 2'b00, exp_done, exp_done);
      end
      if (k == 3) begin
        total++;
        if ({HADDR, HWRITE, HWDATA} !== {a2, 1'b0, w_data}) begin
          bad++;
          $display("FAIL b2b read_issue: got a=%h w=%b wd=%h exp a=%h w=0 wd=%h", HADDR, HWRITE, HWDATA, a2, w_data);
        end
      end
      if (k == 5) begin
        total++;
        if ({rsp_rdata, rsp_err, HWDATA} !== {r_data, 1'b0, w_data}) begin
          bad++;
          $display("FAIL b2b read_done: got rd=%h e=%b wd=%h exp rd=%h e=0 wd=%h", rsp_rdata, rsp_err, HWDATA, r_data, w_data);
        end
      end
      if (k == 0) begin
        cmd_write = 1'b0; cmd_addr = a2; cmd_wdata = $urandom;
      end
      if (k == 3) cmd_valid = 1'b0;
      HRDATA = (k == 4) ? r_data : $urandom;
    end
    m_hwdata = w_data; m_rdata = r_data; m_err = 1'b0; m_timeout = 1'b0;
  endtask

  task automatic test_random();
    int wait_tab[8] = '{0, 1, 2, 3, 15, 16, 17, 20};
    bit wr, err;
    int waits, stall;
    for (int n = 0; n < 24; n++) begin
      wr    = 1'($urandom);
      waits = wait_tab[$urandom_range(7, 0)];
      stall = $urandom_range(2, 0);
      err   = ($urandom_range(3, 0) == 0) && (waits > 0);
      run_txn(wr, $urandom, $urandom, $urandom, stall, waits, err, "random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0400; cmd_wdata = 32'h9999_AAAA;
    HREADY = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    cmd_valid = 1'b0; HREADY = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HREADY = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    total++;
    if ({HTRANS, HADDR, HWRITE, HWDATA, rsp_valid, timeout_flag, cmd_ready} !==
        {2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_mid async: got tr=%b a=%h w=%b wd=%h v=%b to=%b rdy=%b exp zeros rdy=1",
               HTRANS, HADDR, HWRITE, HWDATA, rsp_valid, timeout_flag, cmd_ready);
    end
    HREADY = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    m_hwdata = '0; m_rdata = '0; m_err = 1'b0; m_timeout = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge HCLK);
      total++;
      if ({rsp_valid, cmd_ready, HTRANS, rsp_rdata} !== {1'b0, 1'b1, 2'b00, 32'h0}) begin
        bad++;
        $display("FAIL reset_mid after[%0d]: got v=%b rdy=%b tr=%b rd=%h exp v=0 rdy=1 tr=00 rd=0",
                 k, rsp_valid, cmd_ready, HTRANS, rsp_rdata);
      end
    end
    run_txn(1'b0, 32'h0000_0500, 32'h0, 32'h600D_CAFE, 0, 1, 1'b0, "post_reset");
  endtask

  initial begin
    test_reset();
    test_write_min();
    test_read_waits();
    test_error();
    test_timeout();
    test_addr_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- AHB-Lite initiator that turns a simple single-command request interface into AHB-Lite single transfers: address phase, then data phase.
- It is the opposite end of the AHB slave/memory interface. Its bus outputs connect to the slave's HADDR/HWRITE/HWDATA/HSEL path.
- It samples HREADY/HRESP/HRDATA from the slave and returns read data and status to the local requester.
- One transfer is outstanding at a time. Burst and locked transfers are not supported.

Parameters:
- TIMEOUT_CYCLES, 16: number of consecutive data-phase wait states (HREADY=0) after which timeout_flag asserts.
- CNT_W, 5: width of the wait-state counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- HCLK  input  1  system clock, rising-edge active
- HRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  requester presents a command
- cmd_ready  output  1  block can accept a command this cycle
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  32  byte address
- cmd_wdata  input  32  write data
- HADDR  output  32  AHB address
- HTRANS  output  2  AHB transfer type (00 IDLE, 10 NONSEQ only)
- HWRITE  output  1  AHB direction
- HSIZE  output  3  constant 3'b010 (word)
- HWDATA  output  32  AHB write data
- HREADY  input  1  slave ready (HREADYOUT of the slave)
- HRESP  input  1  slave response, 1=ERROR
- HRDATA  input  32  slave read data
- rsp_valid  output  1  one-cycle pulse: transfer complete
- rsp_rdata  output  32  captured read data; 0 for writes
- rsp_err  output  1  transfer ended with HRESP=1; valid with rsp_valid
- timeout_flag  output  1  sticky: wait-state limit reached on current/last transfer

Behaviour:
- One clock (HCLK). Reset is asynchronous and active-low (HRESETn).
- All outputs and state are registered except cmd_ready, which is decoded from state.
- Reset values:
  - state=IDLE, HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout_flag=0, wait counter=0.
  - HSIZE is always 3'b010.
- Reset asserted mid-transfer: the transfer is abandoned immediately. HTRANS returns to 00 asynchronously and no response is produced.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - cmd_ready=1, HTRANS=00.
  - On a rising edge with cmd_valid=1: latch cmd_addr into HADDR, cmd_write into HWRITE, and cmd_wdata into the internal wdata register.
  - Also on that edge: clear timeout_flag and the wait counter, set HTRANS=10, go to ADDR.
- ADDR:
  - cmd_ready=0. HTRANS=10; HADDR/HWRITE held.
  - The address phase completes on the first rising edge with HREADY=1. On that edge: HTRANS<=00, HWDATA<=wdata register (writes only; HWDATA unchanged for reads), go to DATA.
  - HREADY=0 in ADDR (previous transfer stall): hold all outputs, stay in ADDR, wait counter not incremented.
- DATA:
  - cmd_ready=0, HTRANS=00, HWDATA held stable for the whole data phase.
  - Each edge with HREADY=0: wait counter increments, saturating at 2^CNT_W-1. When the counter reaches TIMEOUT_CYCLES, timeout_flag<=1.
  - The transfer is never abandoned on timeout; the block stays in DATA until HREADY=1.
  - Edge with HREADY=1: rsp_valid<=1 and rsp_err<=HRESP. rsp_rdata<=HRDATA if the transfer is a read and HRESP=0, else 0. Go to IDLE.
  - Two-cycle ERROR response (HRESP=1,HREADY=0 then HRESP=1,HREADY=1): the first cycle counts as a wait state; completion occurs on the second cycle with rsp_err=1.
- rsp_valid is high for exactly one cycle. rsp_rdata/rsp_err hold their values until the next completion.
- Minimum latency: cmd accept edge → 1 cycle address phase → 1 cycle data phase. rsp_valid is asserted 2 cycles after the accept edge when HREADY=1 throughout.
- Back-to-back: cmd_ready=1 during the rsp_valid cycle (state IDLE). A new command accepted then gives a minimum 3-cycle issue interval.
- cmd_valid while cmd_ready=0 is ignored. The requester holds the command until accepted.

Test Plan:
- Reset, then write: addr 0x0000_3A7C, data 0xFFFF_FFFF, HREADY=1 → HTRANS=10/HWRITE=1/HADDR=0x3A7C for one cycle, then HWDATA=0xFFFF_FFFF with HTRANS=00; rsp_valid pulse 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read at addr 0x0000_1D3A, slave returns HRDATA=0xDEAD_BEEF with 2 wait states → rsp_valid 4 cycles after accept, rsp_rdata=0xDEAD_BEEF, timeout_flag=0.
- Two-cycle ERROR on a read (HRESP=1,HREADY=0; then HRESP=1,HREADY=1) → rsp_err=1, rsp_rdata=0, single rsp_valid pulse, state IDLE.
- HREADY held 0 for 20 data-phase cycles with TIMEOUT_CYCLES=16 → timeout_flag=1 after the 16th wait edge and stays in DATA; on HREADY=1, rsp_valid=1. Next accepted command clears timeout_flag.
- Back-to-back write then read with cmd_valid held high → second NONSEQ starts 3 cycles after the first; no HTRANS=10 during any data phase; cmd_ready=0 in ADDR/DATA.
- HRESETn pulled low during DATA with HREADY=0 → all outputs reset immediately (HTRANS=00, rsp_valid=0); after release, no spurious rsp_valid and cmd_ready=1.
